// File: rtl/fetch_stage_if.sv
// Fetch stage bus bundle: instruction-memory request/response, execute
// redirect, and the valid/ready path into decode.
// master = fetch_stage side, slave = surrounding datapath / memory side.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [31:0] pc;
    logic        fetch_fault;

    modport master (
        output imem_req, imem_addr,
        input  imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instr, opcode, pc, fetch_fault
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instr, opcode, pc, fetch_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage. Single outstanding imem request, one
// instruction held for decode at a time, PC redirects from execute.
// Optional macro FETCH_MISALIGN_TRAP_EN: a redirect to a non-word-aligned
// target parks the stage in FAULT until reset; without it the low two
// target bits are simply cleared.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] pc_q;
    logic [31:0] req_addr;
    logic [31:0] req_next;
    logic        flush_pending;
    logic [31:0] instr_q;

    logic        redir_go;
    logic [31:0] redir_tgt;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        redir_bad;
    assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    assign redir_go  = bus.redirect_valid && !redir_bad;
    assign redir_tgt = bus.redirect_pc;
`else
    assign redir_go  = bus.redirect_valid;
    assign redir_tgt = {bus.redirect_pc[31:2], 2'b00};
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state: redirect outranks everything, a response only advances
    // to HOLD when it is neither stale nor overtaken by a same-cycle redirect
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (bus.imem_rvalid && !flush_pending && !bus.redirect_valid)
                      state_nxt = HOLD;
            HOLD: if (bus.redirect_valid || bus.instr_ready)
                      state_nxt = REQ;
            default: state_nxt = state;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (redir_bad) state_nxt = FAULT;
        if (state == FAULT) state_nxt = FAULT;
`endif
    end

    // Datapath: request address, pending-flush bookkeeping, held instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            req_addr      <= RESET_PC;
            req_next      <= RESET_PC;
            flush_pending <= 1'b0;
            instr_q       <= 32'h0;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        else if (redir_bad && state != FAULT) begin
            pc_q          <= bus.redirect_pc;
            flush_pending <= 1'b0;
        end
`endif
        else begin
            case (state)
                IDLE: if (redir_go) req_addr <= redir_tgt;
                REQ: begin
                    if (redir_go) begin
                        // Address must stay stable until the response lands,
                        // so a redirect without rvalid is parked in req_next.
                        if (bus.imem_rvalid) begin
                            req_addr      <= redir_tgt;
                            flush_pending <= 1'b0;
                        end else begin
                            req_next      <= redir_tgt;
                            flush_pending <= 1'b1;
                        end
                    end else if (bus.imem_rvalid) begin
                        if (flush_pending) begin
                            req_addr      <= req_next;
                            flush_pending <= 1'b0;
                        end else begin
                            instr_q <= bus.imem_rdata;
                            pc_q    <= req_addr;
                        end
                    end
                end
                HOLD: begin
                    if (redir_go)             req_addr <= redir_tgt;
                    else if (bus.instr_ready) req_addr <= pc_q + PC_STEP;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state
    always_comb begin
        bus.imem_req    = (state == REQ);
        bus.imem_addr   = req_addr;
        bus.instr_valid = (state == HOLD);
        bus.instr       = instr_q;
        bus.opcode      = instr_q[6:0];
        bus.pc          = pc_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        bus.fetch_fault = (state == FAULT);
`else
        bus.fetch_fault = 1'b0;
`endif
    end

endmodule
